// File: rtl/qam_p2s.sv
// Receive-side symbol FIFO and cos-then-sin bit serializer for the QAM/QPSK link.
// Optional differential decoding is enabled by defining QAM_P2S_DIFF_DECODE_EN.
module qam_p2s #(
  parameter int unsigned BIT_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sym_valid,
  input  logic elojel_cos,
  input  logic elojel_sin,
  output logic sym_ready,
  output logic adat_ki_S,
  output logic bit_valid,
  output logic busy,
  output logic overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0]    DIV_MAX = 8'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BIT0, BIT1} state_t;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_div;
  logic [1:0]    r_shift;
  logic          r_overflow;
  state_t        r_state, w_next_state;
  logic          w_full, w_empty, w_push, w_pop, w_reload;
  logic [1:0]    w_raw, w_pair;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count, so a same-edge pop never rescues a write.
  assign w_push  = sym_valid & ~w_full;
  assign w_raw   = r_mem[r_rd_ptr];

`ifdef QAM_P2S_DIFF_DECODE_EN
  logic [1:0] r_prev;
  assign w_pair = w_raw ^ r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_prev <= '0;
    else if (w_pop) r_prev <= w_raw;
  end
`else
  assign w_pair = w_raw;
`endif

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {elojel_cos, elojel_sin};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (sym_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) r_shift <= w_pair;
      if (w_reload)                         r_div <= DIV_MAX;
      else if (r_state != IDLE && r_div != '0) r_div <= r_div - 8'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_reload     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_reload     = 1'b1;
          w_next_state = BIT0;
        end
      end
      BIT0: begin
        if (r_div == '0) begin
          w_reload     = 1'b1;
          w_next_state = BIT1;
        end
      end
      BIT1: begin
        if (r_div == '0) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_reload     = 1'b1;
            w_next_state = BIT0;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    adat_ki_S = 1'b0;
    case (r_state)
      BIT0:    adat_ki_S = r_shift[1];
      BIT1:    adat_ki_S = r_shift[0];
      default: adat_ki_S = 1'b0;
    endcase
  end

  // The divider is reloaded on entry to every bit, so its top value marks the first cycle.
  assign busy      = (r_state != IDLE);
  assign bit_valid = busy && (r_div == DIV_MAX);
  assign sym_ready = ~w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_qam_p2s.sv
// Self-checking bench for qam_p2s: main instance (BIT_PERIOD=4, depth 4) and a BIT_PERIOD=1 instance.
module tb_qam_p2s;

  localparam int BP = 4;
`ifdef QAM_P2S_DIFF_DECODE_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sym_valid = 1'b0, elojel_cos = 1'b0, elojel_sin = 1'b0;
  logic sym_ready, adat_ki_S, bit_valid, busy, overflow;
  logic f_valid = 1'b0, f_cos = 1'b0, f_sin = 1'b0;
  logic f_ready, f_dat, f_bv, f_busy, f_ovf;

  int checks = 0;
  int errors = 0;
  logic [1:0] m_prev_main = 2'b00;
  logic [1:0] m_prev_fast = 2'b00;
  logic cap_q[$];

  always #5 clock = ~clock;

  qam_p2s #(.BIT_PERIOD(BP), .FIFO_DEPTH(4)) u_main (
    .clock(clock), .reset(reset), .sym_valid(sym_valid),
    .elojel_cos(elojel_cos), .elojel_sin(elojel_sin),
    .sym_ready(sym_ready), .adat_ki_S(adat_ki_S), .bit_valid(bit_valid),
    .busy(busy), .overflow(overflow)
  );

  qam_p2s #(.BIT_PERIOD(1), .FIFO_DEPTH(4)) u_fast (
    .clock(clock), .reset(reset), .sym_valid(f_valid),
    .elojel_cos(f_cos), .elojel_sin(f_sin),
    .sym_ready(f_ready), .adat_ki_S(f_dat), .bit_valid(f_bv),
    .busy(f_busy), .overflow(f_ovf)
  );

  always @(negedge clock) if (reset && bit_valid) cap_q.push_back(adat_ki_S);

  // Reference: each popped raw pair becomes two serial bits, optionally XORed with the previous raw pair.
  task automatic model_pop(input int which, input logic [1:0] raw, output logic [1:0] ser);
    if (which == 0) begin
      ser = DIFF ? (raw ^ m_prev_main) : raw;
      m_prev_main = raw;
    end else begin
      ser = DIFF ? (raw ^ m_prev_fast) : raw;
      m_prev_fast = raw;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    m_prev_main = 2'b00;
    m_prev_fast = 2'b00;
    cap_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({adat_ki_S, bit_valid, busy, sym_ready, overflow} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00010", {adat_ki_S, bit_valid, busy, sym_ready, overflow});
    end
    checks++;
    if ({f_dat, f_bv, f_busy, f_ready, f_ovf} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_outputs_fast got %b exp 00010", {f_dat, f_bv, f_busy, f_ready, f_ovf});
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [1:0] p;
    logic ed, ebv, eb;
    model_pop(0, 2'b10, p);
    @(posedge clock); #1;
    sym_valid = 1'b1; elojel_cos = 1'b1; elojel_sin = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      ed  = (c >= 2 && c <= 1 + BP) ? p[1] : (c >= 2 + BP && c <= 1 + 2 * BP) ? p[0] : 1'b0;
      ebv = (c == 2) || (c == 2 + BP);
      eb  = (c >= 2) && (c <= 1 + 2 * BP);
      checks++;
      if ({adat_ki_S, bit_valid, busy} !== {ed, ebv, eb}) begin
        errors++;
        $display("FAIL single_c%0d got dat/bv/busy %b exp %b", c, {adat_ki_S, bit_valid, busy}, {ed, ebv, eb});
      end
      @(posedge clock); #1 sym_valid = 1'b0;
    end
  endtask

  task automatic test_stream();
    logic exp_q[$];
    logic [1:0] raw, ser;
    int sent = 0;
    int k;
    cap_q.delete();
    while (sent < 16) begin
      @(posedge clock); #1;
      sym_valid = 1'b0;
      if (sym_ready && $urandom_range(0, 3) != 0) begin
        raw = 2'($urandom_range(0, 3));
        sym_valid = 1'b1; {elojel_cos, elojel_sin} = raw;
        model_pop(0, raw, ser);
        exp_q.push_back(ser[1]); exp_q.push_back(ser[0]);
        sent++;
      end
    end
    @(posedge clock); #1 sym_valid = 1'b0;
    k = 0;
    while (k < 1000 && cap_q.size() < exp_q.size()) begin @(negedge clock); k++; end
    repeat (3) @(negedge clock);
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stream_len got %0d exp %0d", cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stream_bit%0d got %b exp %b", i, cap_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({busy, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL stream_idle got busy/ovf %b exp 00", {busy, overflow});
    end
  endtask

  task automatic test_overflow();
    logic [1:0] syms[6];
    logic [1:0] ser;
    logic exp_q[$];
    int k;
    cap_q.delete();
    for (int i = 0; i < 6; i++) syms[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 5; i++) begin
      model_pop(0, syms[i], ser);
      exp_q.push_back(ser[1]); exp_q.push_back(ser[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      sym_valid = 1'b1; {elojel_cos, elojel_sin} = syms[i];
    end
    @(posedge clock); #1 sym_valid = 1'b0;
    checks++;
    if ({sym_ready, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_full got ready/ovf %b exp 01", {sym_ready, overflow});
    end
    k = 0;
    while (k < 1000 && cap_q.size() < 10) begin @(negedge clock); k++; end
    repeat (3) @(negedge clock);
    checks++;
    if (cap_q.size() != 10) begin
      errors++;
      $display("FAIL ovf_len got %0d exp 10", cap_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL ovf_bit%0d got %b exp %b", i, cap_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({sym_ready, overflow, busy} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_sticky got ready/ovf/busy %b exp 110", {sym_ready, overflow, busy});
    end
  endtask

  task automatic test_reset_midbit();
    logic [1:0] p;
    int act;
    model_pop(0, 2'b01, p);
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      sym_valid = (c < 3);
      {elojel_cos, elojel_sin} = 2'b01;
    end
    checks++;
    if ({busy, adat_ki_S} !== {1'b1, p[0]}) begin
      errors++;
      $display("FAIL midbit_pre got busy/dat %b exp %b", {busy, adat_ki_S}, {1'b1, p[0]});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({adat_ki_S, bit_valid, busy, sym_ready, overflow} !== 5'b00010) begin
      errors++;
      $display("FAIL midbit_reset got %b exp 00010", {adat_ki_S, bit_valid, busy, sym_ready, overflow});
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    m_prev_main = 2'b00; m_prev_fast = 2'b00;
    cap_q.delete();
    act = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (busy || bit_valid || adat_ki_S) act++;
    end
    checks++;
    if (act != 0 || cap_q.size() != 0) begin
      errors++;
      $display("FAIL midbit_stale got active_cycles %0d bits %0d exp 0 0", act, cap_q.size());
    end
  endtask

  task automatic test_bp1();
    logic [1:0] p[3];
    logic ed;
    for (int i = 0; i < 3; i++) model_pop(1, 2'b10, p[i]);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      f_valid = (c < 3); {f_cos, f_sin} = 2'b10;
      @(negedge clock);
      if (c >= 2 && c <= 7) begin
        ed = ((c - 2) % 2 == 0) ? p[(c - 2) / 2][1] : p[(c - 2) / 2][0];
        checks++;
        if ({f_dat, f_bv, f_busy} !== {ed, 2'b11}) begin
          errors++;
          $display("FAIL bp1_c%0d got dat/bv/busy %b exp %b", c, {f_dat, f_bv, f_busy}, {ed, 2'b11});
        end
      end else if (c >= 8) begin
        checks++;
        if ({f_bv, f_busy} !== 2'b00) begin
          errors++;
          $display("FAIL bp1_end_c%0d got bv/busy %b exp 00", c, {f_bv, f_busy});
        end
      end
    end
  endtask

  task automatic test_diff_pattern();
    logic [1:0] raw[3];
    logic [1:0] ser;
    logic exp_q[$];
    int k;
    raw[0] = 2'b11; raw[1] = 2'b11; raw[2] = 2'b01;
    cap_q.delete();
    for (int i = 0; i < 3; i++) begin
      model_pop(0, raw[i], ser);
      exp_q.push_back(ser[1]); exp_q.push_back(ser[0]);
      @(posedge clock); #1;
      sym_valid = 1'b1; {elojel_cos, elojel_sin} = raw[i];
    end
    @(posedge clock); #1 sym_valid = 1'b0;
    k = 0;
    while (k < 500 && cap_q.size() < 6) begin @(negedge clock); k++; end
    checks++;
    if (cap_q.size() != 6) begin
      errors++;
      $display("FAIL diff_len got %0d exp 6", cap_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL diff_bit%0d got %b exp %b", i, cap_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_reset_midbit();
    test_bp1();
    do_reset();
    test_diff_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
